// File: rtl/bp_be_lce_req_arbiter_pkg.sv
// Shared types for the back-end LCE request arbiter.
package bp_be_pkg;

    typedef enum logic {
        e_lce_req_src_dcache = 1'b0,
        e_lce_req_src_ptw    = 1'b1
    } bp_be_lce_req_src_e;

    function automatic bp_be_lce_req_src_e other_src(input bp_be_lce_req_src_e src);
        return (src == e_lce_req_src_dcache) ? e_lce_req_src_ptw : e_lce_req_src_dcache;
    endfunction

endpackage

// File: rtl/bp_be_lce_req_arbiter_if.sv
// Requester, network and credit signals of the LCE request arbiter.
interface bp_be_lce_req_arbiter_if
    import bp_be_pkg::*;
#(
    parameter int unsigned req_width_p = 128
) ();

    logic [req_width_p-1:0] req0_i;
    logic                   req0_v_i;
    logic                   req0_ready_o;
    logic [req_width_p-1:0] req1_i;
    logic                   req1_v_i;
    logic                   req1_ready_o;
    logic [req_width_p-1:0] lce_req_o;
    logic                   lce_req_v_o;
    logic                   lce_req_ready_i;
    bp_be_lce_req_src_e     lce_req_grant_o;
    logic                   credit_return_i;
    logic                   credits_full_o;
    logic                   credits_empty_o;

    modport master (
        output req0_i, req0_v_i, req1_i, req1_v_i, lce_req_ready_i, credit_return_i,
        input  req0_ready_o, req1_ready_o, lce_req_o, lce_req_v_o, lce_req_grant_o,
               credits_full_o, credits_empty_o
    );

    modport slave (
        input  req0_i, req0_v_i, req1_i, req1_v_i, lce_req_ready_i, credit_return_i,
        output req0_ready_o, req1_ready_o, lce_req_o, lce_req_v_o, lce_req_grant_o,
               credits_full_o, credits_empty_o
    );

endinterface

// File: rtl/bp_be_lce_req_arbiter_buf.sv
// One-entry valid/data buffer; a slot cannot fill and drain in the same cycle.
module bp_be_lce_req_buf #(
    parameter int unsigned width_p = 128
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    input  logic               yumi_i,
    output logic [width_p-1:0] data_o
);

    logic               v_r;
    logic [width_p-1:0] data_r;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            v_r <= 1'b0;
        end else if (v_i && ready_o) begin
            v_r <= 1'b1;
        end else if (yumi_i) begin
            v_r <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (v_i && ready_o) begin
            data_r <= data_i;
        end
    end

    always_comb begin
        ready_o = ~v_r;
        v_o     = v_r;
        data_o  = data_r;
    end

endmodule

// File: rtl/bp_be_lce_req_arbiter.sv
// Round-robin arbiter sharing the LCE request port between the D$ miss path and the PTW,
// with an outstanding-request credit counter.
module bp_be_lce_req_arbiter
    import bp_be_pkg::*;
#(
    parameter int unsigned req_width_p = 128,
    parameter int unsigned credits_p   = 8
) (
    input logic              clk_i,
    input logic              reset_n_i,
    bp_be_lce_req_arbiter_if.slave bus
);

    localparam int unsigned ctr_w = $clog2(credits_p + 1);

    logic                   buf0_v, buf1_v;
    logic                   buf0_ready, buf1_ready;
    logic [req_width_p-1:0] buf0_data, buf1_data;
    logic                   yumi0, yumi1;

    bp_be_lce_req_src_e     last_grant_r;
    bp_be_lce_req_src_e     lock_grant_r;
    logic                   grant_lock_r;
    logic [ctr_w-1:0]       count_r;

    bp_be_lce_req_src_e     grant;
    logic                   full, empty;
    logic                   elig0, elig1;
    logic                   req_v, send;

    bp_be_lce_req_buf #(.width_p(req_width_p)) buf0 (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (bus.req0_v_i & reset_n_i),
        .ready_o   (buf0_ready),
        .data_i    (bus.req0_i),
        .v_o       (buf0_v),
        .yumi_i    (yumi0),
        .data_o    (buf0_data)
    );

    bp_be_lce_req_buf #(.width_p(req_width_p)) buf1 (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (bus.req1_v_i & reset_n_i),
        .ready_o   (buf1_ready),
        .data_i    (bus.req1_i),
        .v_o       (buf1_v),
        .yumi_i    (yumi1),
        .data_o    (buf1_data)
    );

    // A locked grant overrides round-robin so the offered message stays put until sent.
    always_comb begin
        full  = (count_r == ctr_w'(credits_p));
        empty = (count_r == '0);
        elig0 = buf0_v & ~full;
        elig1 = buf1_v & ~full;
        grant = e_lce_req_src_dcache;
        if (grant_lock_r) begin
            grant = lock_grant_r;
        end else if (elig0 && elig1) begin
            grant = other_src(last_grant_r);
        end else if (elig1) begin
            grant = e_lce_req_src_ptw;
        end
        req_v = reset_n_i & ~full & (grant_lock_r | elig0 | elig1);
        send  = req_v & bus.lce_req_ready_i;
        yumi0 = send & (grant == e_lce_req_src_dcache);
        yumi1 = send & (grant == e_lce_req_src_ptw);
    end

    always_comb begin
        bus.req0_ready_o    = buf0_ready & reset_n_i;
        bus.req1_ready_o    = buf1_ready & reset_n_i;
        bus.lce_req_o       = (grant == e_lce_req_src_ptw) ? buf1_data : buf0_data;
        bus.lce_req_v_o     = req_v;
        bus.lce_req_grant_o = grant;
        bus.credits_full_o  = full & reset_n_i;
        bus.credits_empty_o = empty | ~reset_n_i;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            last_grant_r <= e_lce_req_src_ptw;
            lock_grant_r <= e_lce_req_src_dcache;
            grant_lock_r <= 1'b0;
        end else if (send) begin
            last_grant_r <= grant;
            grant_lock_r <= 1'b0;
        end else if (req_v) begin
            lock_grant_r <= grant;
            grant_lock_r <= 1'b1;
        end
    end

    // A return arriving with nothing outstanding is dropped rather than wrapping the count.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            count_r <= '0;
        end else if (send && !bus.credit_return_i) begin
            count_r <= count_r + 1'b1;
        end else if (!send && bus.credit_return_i && !empty) begin
            count_r <= count_r - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(bus.credit_return_i && empty))
            else $warning("credit_return_i with no outstanding requests");
        end
    end

endmodule

// File: tb/tb_bp_be_lce_req_arbiter.sv
// Bench for bp_be_lce_req_arbiter: directed scenarios then random traffic, checked against a
// per-cycle behavioural model of the two buffers, round-robin choice and credit count.
module tb_bp_be_lce_req_arbiter;
    import bp_be_pkg::*;

    localparam int unsigned W = 128;
    localparam int CREDITS = 8;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    bp_be_lce_req_arbiter_if #(.req_width_p(W)) bus ();

    bp_be_lce_req_arbiter #(.req_width_p(W), .credits_p(CREDITS)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    string phase = "init";

    // model state: pending message per requester, who won last, committed winner, outstanding
    bit         pend[2];
    logic [W-1:0] msg[2];
    int         last_winner;
    bit         committed;
    int         committed_id;
    int         outstanding;

    function automatic logic [W-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst_n, input bit v0, input logic [W-1:0] d0,
                        input bit v1, input logic [W-1:0] d1, input bit rdy, input bit ret);
        bit e_full, e_empty, e_v, sent;
        int e_id, n_cand;
        reset_n             = rst_n;
        bus.req0_v_i        = v0;
        bus.req0_i          = d0;
        bus.req1_v_i        = v1;
        bus.req1_i          = d1;
        bus.lce_req_ready_i = rdy;
        bus.credit_return_i = ret;

        e_full  = (outstanding == CREDITS);
        e_empty = (outstanding == 0);
        n_cand  = (e_full ? 0 : int'(pend[0]) + int'(pend[1]));
        e_v     = 1'b0;
        e_id    = 0;
        if (!e_full && committed) begin
            e_v  = 1'b1;
            e_id = committed_id;
        end else if (n_cand == 2) begin
            e_v  = 1'b1;
            e_id = 1 - last_winner;
        end else if (n_cand == 1) begin
            e_v  = 1'b1;
            e_id = pend[1] ? 1 : 0;
        end

        @(negedge clk);
        if (!rst_n) begin
            check("rdy0_rst", W'(bus.req0_ready_o), W'(1'b0));
            check("rdy1_rst", W'(bus.req1_ready_o), W'(1'b0));
            check("v_rst", W'(bus.lce_req_v_o), W'(1'b0));
            check("empty_rst", W'(bus.credits_empty_o), W'(1'b1));
        end else begin
            check("rdy0", W'(bus.req0_ready_o), W'(!pend[0]));
            check("rdy1", W'(bus.req1_ready_o), W'(!pend[1]));
            check("v", W'(bus.lce_req_v_o), W'(e_v));
            check("full", W'(bus.credits_full_o), W'(e_full));
            check("empty", W'(bus.credits_empty_o), W'(e_empty));
            if (e_v) begin
                check("grant", W'(bus.lce_req_grant_o), W'(e_id));
                check("data", bus.lce_req_o, msg[e_id]);
            end
        end

        @(posedge clk);
        if (!rst_n) begin
            pend[0] = 1'b0;
            pend[1] = 1'b0;
            last_winner = 1;
            committed = 1'b0;
            outstanding = 0;
        end else begin
            sent = e_v && rdy;
            if (v0 && !pend[0]) begin
                pend[0] = 1'b1;
                msg[0]  = d0;
            end else if (sent && e_id == 0) begin
                pend[0] = 1'b0;
            end
            if (v1 && !pend[1]) begin
                pend[1] = 1'b1;
                msg[1]  = d1;
            end else if (sent && e_id == 1) begin
                pend[1] = 1'b0;
            end
            if (sent) begin
                last_winner = e_id;
                committed   = 1'b0;
            end else if (e_v) begin
                committed    = 1'b1;
                committed_id = e_id;
            end
            if (sent && !ret) outstanding++;
            else if (!sent && ret && outstanding > 0) outstanding--;
        end
        #1;
    endtask

    task automatic idle(input bit rdy, input int n);
        for (int i = 0; i < n; i++) step(1, 0, '0, 0, '0, rdy, 0);
    endtask

    initial begin
        logic [W-1:0] a, b;
        bit r0, r1, rd, rt;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        last_winner = 1;
        committed = 1'b0;
        committed_id = 0;
        outstanding = 0;

        phase = "reset";
        step(0, 0, '0, 0, '0, 0, 0);
        step(0, 1, rnd128(), 1, rnd128(), 1, 0);
        idle(1, 1);

        phase = "solo";
        a = rnd128();
        step(1, 1, a, 0, '0, 1, 0);
        idle(1, 2);

        phase = "tie";
        a = rnd128(); b = rnd128();
        step(1, 1, a, 1, b, 1, 0);
        idle(1, 3);
        step(1, 1, rnd128(), 1, rnd128(), 1, 0);
        idle(1, 3);

        phase = "backpressure";
        step(1, 1, rnd128(), 1, rnd128(), 0, 0);
        idle(0, 5);
        idle(1, 3);

        phase = "credits";
        step(0, 0, '0, 0, '0, 0, 0);
        for (int i = 0; i < CREDITS; i++) begin
            step(1, 1, rnd128(), 0, '0, 1, 0);
            idle(1, 1);
        end
        step(1, 1, rnd128(), 0, '0, 1, 0);
        idle(1, 2);
        step(1, 0, '0, 0, '0, 1, 1);
        idle(1, 2);
        step(1, 0, '0, 1, rnd128(), 1, 1);
        step(1, 0, '0, 0, '0, 1, 1);
        idle(1, 2);

        phase = "return_at_empty";
        step(0, 0, '0, 0, '0, 0, 0);
        step(1, 0, '0, 0, '0, 1, 1);
        idle(1, 1);
        step(1, 1, rnd128(), 0, '0, 1, 0);
        idle(1, 2);
        step(1, 0, '0, 0, '0, 1, 1);
        idle(1, 1);

        phase = "reset_midflight";
        for (int i = 0; i < 3; i++) begin
            step(1, 0, '0, 1, rnd128(), 1, 0);
            idle(1, 1);
        end
        step(1, 1, rnd128(), 1, rnd128(), 0, 0);
        idle(0, 1);
        step(0, 0, '0, 0, '0, 0, 0);
        idle(1, 2);

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            r0 = ($urandom_range(0, 2) != 0);
            r1 = ($urandom_range(0, 2) != 0);
            rd = ($urandom_range(0, 3) != 0);
            rt = ($urandom_range(0, 3) == 0) && (outstanding > 0);
            step(1, r0, rnd128(), r1, rnd128(), rd, rt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
